// File: rtl/answer_checker.sv
// Bulls-and-cows style scorer: latches a secret answer, scores guesses one digit per cycle.
// Define ATTEMPT_LIMIT_EN to enable the per-answer try counter and game_over.
// The generator's rand output enters on rand_data because rand is a reserved word.
module answer_checker #(
   parameter int unsigned DIGITS    = 4,
   parameter int unsigned MAX_TRIES = 10
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [31:0]         rand_data,
   input  logic                write_enable,
   input  logic [4*DIGITS-1:0] guess,
   input  logic                guess_valid,
   output logic                guess_ready,
   output logic [4*DIGITS-1:0] answer,
   output logic                answer_valid,
   output logic [3:0]          strike,
   output logic [3:0]          ball,
   output logic                result_valid,
   output logic                win,
   output logic [3:0]          tries_left,
   output logic                game_over
);

   localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {StIdle, StCheck, StDone} state_e;

   state_e              state;
   logic [4*DIGITS-1:0] guess_q;
   logic [IdxW-1:0]     idx;
   logic [3:0]          cur_digit;
   logic                hit_strike;
   logic                hit_ball;
   logic [3:0]          strike_nxt;
   logic [3:0]          ball_nxt;

   assign guess_ready = (state == StIdle) && answer_valid && !win && !game_over;

   // A digit counts as a ball at most once, however many other positions hold it.
   always_comb begin
      cur_digit  = guess_q[4*idx +: 4];
      hit_strike = (cur_digit == answer[4*idx +: 4]);
      hit_ball   = 1'b0;
      for (int j = 0; j < DIGITS; j++) begin
         if ((j != int'(idx)) && (answer[4*j +: 4] == cur_digit)) hit_ball = 1'b1;
      end
      strike_nxt = strike + {3'b000, hit_strike};
      ball_nxt   = ball + {3'b000, (!hit_strike && hit_ball)};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= StIdle;
         guess_q      <= '0;
         idx          <= '0;
         answer       <= '0;
         answer_valid <= 1'b0;
         strike       <= '0;
         ball         <= '0;
         result_valid <= 1'b0;
         win          <= 1'b0;
`ifdef ATTEMPT_LIMIT_EN
         tries_left   <= 4'(MAX_TRIES);
         game_over    <= 1'b0;
`endif
      end else if (write_enable) begin
         // A load wins over any handshake and aborts a scan in flight.
         state        <= StIdle;
         idx          <= '0;
         answer       <= rand_data[4*DIGITS-1:0];
         answer_valid <= 1'b1;
         strike       <= '0;
         ball         <= '0;
         result_valid <= 1'b0;
         win          <= 1'b0;
`ifdef ATTEMPT_LIMIT_EN
         tries_left   <= 4'(MAX_TRIES);
         game_over    <= 1'b0;
`endif
      end else begin
         result_valid <= 1'b0;
         case (state)
            StIdle: begin
               if (guess_valid && guess_ready) begin
                  guess_q <= guess;
                  idx     <= '0;
                  strike  <= '0;
                  ball    <= '0;
                  state   <= StCheck;
               end
            end
            StCheck: begin
               strike <= strike_nxt;
               ball   <= ball_nxt;
               if (idx == IdxW'(DIGITS - 1)) begin
                  // Final scan step: publish result as the FSM enters DONE.
                  state        <= StDone;
                  result_valid <= 1'b1;
                  if (strike_nxt == 4'(DIGITS)) begin
                     win <= 1'b1;
                  end
`ifdef ATTEMPT_LIMIT_EN
                  else if (tries_left != 4'd0) begin
                     tries_left <= tries_left - 4'd1;
                     if (tries_left == 4'd1) game_over <= 1'b1;
                  end
`endif
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            StDone:  state <= StIdle;
            default: state <= StIdle;
         endcase
      end
   end

`ifndef ATTEMPT_LIMIT_EN
   assign tries_left = 4'd0;
   assign game_over  = 1'b0;
`endif

endmodule

// File: tb/tb_answer_checker.sv
// Directed self-checking bench for answer_checker (DIGITS=4, MAX_TRIES=10).
// Exercises the try-limit scenario when ATTEMPT_LIMIT_EN is defined.
module tb_answer_checker;

   localparam int unsigned DIGITS = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] rand_data;
   logic        write_enable;
   logic [15:0] guess;
   logic        guess_valid;
   logic        guess_ready;
   logic [15:0] answer;
   logic        answer_valid;
   logic [3:0]  strike;
   logic [3:0]  ball;
   logic        result_valid;
   logic        win;
   logic [3:0]  tries_left;
   logic        game_over;

   int tests = 0;
   int fails = 0;

`ifdef ATTEMPT_LIMIT_EN
   localparam logic [3:0] RstTries = 4'd10;
`else
   localparam logic [3:0] RstTries = 4'd0;
`endif

   answer_checker #(.DIGITS(DIGITS), .MAX_TRIES(10)) dut (
      .clk          (clk),
      .rst          (rst),
      .rand_data    (rand_data),
      .write_enable (write_enable),
      .guess        (guess),
      .guess_valid  (guess_valid),
      .guess_ready  (guess_ready),
      .answer       (answer),
      .answer_valid (answer_valid),
      .strike       (strike),
      .ball         (ball),
      .result_valid (result_valid),
      .win          (win),
      .tries_left   (tries_left),
      .game_over    (game_over)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [31:0] val);
      rand_data    = val;
      write_enable = 1'b1;
      tick();
      write_enable = 1'b0;
   endtask

   // Handshake one guess, then count cycles until result_valid (bounded).
   task automatic submit(input logic [15:0] g, output int lat);
      guess       = g;
      guess_valid = 1'b1;
      tick();
      guess_valid = 1'b0;
      guess       = 16'hFFFF;
      lat = 0;
      while (!result_valid && lat < 20) begin
         tick();
         lat++;
      end
   endtask

   task automatic test_reset();
      int seen = 0;
      rst = 1'b1; write_enable = 1'b0; guess_valid = 1'b0; guess = '0; rand_data = '0;
      tick(); tick();
      rst = 1'b0;
      tests++; if (answer !== 16'h0) begin fails++; $display("FAIL rst_answer got %h want 0000", answer); end
      tests++; if (answer_valid !== 1'b0) begin fails++; $display("FAIL rst_answer_valid got %b want 0", answer_valid); end
      tests++; if (guess_ready !== 1'b0) begin fails++; $display("FAIL rst_guess_ready got %b want 0", guess_ready); end
      tests++; if ({strike, ball} !== 8'h00) begin fails++; $display("FAIL rst_score got %h/%h want 0/0", strike, ball); end
      tests++; if ({result_valid, win, game_over} !== 3'b000) begin fails++; $display("FAIL rst_flags got %b want 000", {result_valid, win, game_over}); end
      tests++; if (tries_left !== RstTries) begin fails++; $display("FAIL rst_tries got %0d want %0d", tries_left, RstTries); end
      guess = 16'h1234; guess_valid = 1'b1;
      repeat (12) begin
         tick();
         if (result_valid || guess_ready) seen++;
      end
      guess_valid = 1'b0;
      tests++; if (seen !== 0) begin fails++; $display("FAIL noload_guess got %0d activity cycles want 0", seen); end
   endtask

   task automatic test_win();
      int lat;
      do_load(32'h0000_1234);
      tests++; if (answer !== 16'h1234) begin fails++; $display("FAIL load_answer got %h want 1234", answer); end
      tests++; if ({answer_valid, guess_ready} !== 2'b11) begin fails++; $display("FAIL load_ready got %b want 11", {answer_valid, guess_ready}); end
      submit(16'h1234, lat);
      tests++; if (lat !== DIGITS) begin fails++; $display("FAIL win_latency got %0d want %0d", lat, DIGITS); end
      tests++; if ({strike, ball, win} !== {4'd4, 4'd0, 1'b1}) begin fails++; $display("FAIL win_score got s%0d b%0d w%b want s4 b0 w1", strike, ball, win); end
      tick();
      tests++; if ({result_valid, guess_ready, win} !== 3'b001) begin fails++; $display("FAIL win_after got %b want 001", {result_valid, guess_ready, win}); end
      tick();
      tests++; if (guess_ready !== 1'b0) begin fails++; $display("FAIL win_blocks got %b want 0", guess_ready); end
   endtask

   task automatic test_scoring();
      logic [31:0] ans [4] = '{32'h1234, 32'h1234, 32'h1234, 32'h1134};
      logic [15:0] gs  [4] = '{16'h4321, 16'h1243, 16'h5678, 16'h2111};
      logic [3:0]  es  [4] = '{4'd0, 4'd2, 4'd0, 4'd1};
      logic [3:0]  eb  [4] = '{4'd4, 4'd2, 4'd0, 4'd2};
      int lat;
      for (int i = 0; i < 4; i++) begin
         do_load(ans[i]);
         tests++; if (win !== 1'b0) begin fails++; $display("FAIL load_clears_win[%0d] got %b want 0", i, win); end
         submit(gs[i], lat);
         tests++; if (lat !== DIGITS) begin fails++; $display("FAIL score_latency[%0d] got %0d want %0d", i, lat, DIGITS); end
         tests++; if ({strike, ball, win} !== {es[i], eb[i], 1'b0}) begin fails++; $display("FAIL score[%0d] got s%0d b%0d w%b want s%0d b%0d w0", i, strike, ball, win, es[i], eb[i]); end
         tick(); // back in IDLE after the single DONE cycle
         tests++; if ({result_valid, guess_ready} !== 2'b01) begin fails++; $display("FAIL pulse_ready[%0d] got %b want 01", i, {result_valid, guess_ready}); end
         tests++; if ({strike, ball} !== {es[i], eb[i]}) begin fails++; $display("FAIL score_hold[%0d] got s%0d b%0d want s%0d b%0d", i, strike, ball, es[i], eb[i]); end
      end
   endtask

   task automatic test_load_abort();
      int seen = 0;
      do_load(32'h0000_1234);
      guess = 16'h1234; guess_valid = 1'b1;
      tick();
      guess_valid = 1'b0;
      tick(); tick();
      do_load(32'h0000_8765);
      tests++; if (answer !== 16'h8765) begin fails++; $display("FAIL abort_answer got %h want 8765", answer); end
      tests++; if ({result_valid, guess_ready, win, strike, ball} !== {3'b010, 8'h00}) begin fails++; $display("FAIL abort_state got %b %h %h want 010 0 0", {result_valid, guess_ready, win}, strike, ball); end
      repeat (8) begin tick(); if (result_valid) seen++; end
      tests++; if (seen !== 0) begin fails++; $display("FAIL abort_pulse got %0d pulses want 0", seen); end
      guess = 16'h8765; guess_valid = 1'b1; rand_data = 32'h0000_8765; write_enable = 1'b1;
      tick();
      guess_valid = 1'b0; write_enable = 1'b0;
      seen = 0;
      repeat (8) begin tick(); if (result_valid || !guess_ready) seen++; end
      tests++; if (seen !== 0) begin fails++; $display("FAIL load_beats_guess got %0d busy cycles want 0", seen); end
   endtask

   task automatic test_reset_mid();
      int seen = 0;
      do_load(32'h0000_1234);
      guess = 16'h1234; guess_valid = 1'b1;
      tick();
      guess_valid = 1'b0;
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tests++; if ({answer, answer_valid, guess_ready} !== {16'h0, 2'b00}) begin fails++; $display("FAIL midrst_answer got %h %b%b want 0000 00", answer, answer_valid, guess_ready); end
      tests++; if ({strike, ball, result_valid, win, game_over} !== 11'h0) begin fails++; $display("FAIL midrst_score got s%0d b%0d %b want all 0", strike, ball, {result_valid, win, game_over}); end
      tests++; if (tries_left !== RstTries) begin fails++; $display("FAIL midrst_tries got %0d want %0d", tries_left, RstTries); end
      repeat (8) begin tick(); if (result_valid) seen++; end
      tests++; if (seen !== 0) begin fails++; $display("FAIL midrst_pulse got %0d want 0", seen); end
   endtask

   task automatic test_attempt_limit();
      int lat;
      do_load(32'h0000_1234);
`ifdef ATTEMPT_LIMIT_EN
      for (int i = 0; i < 10; i++) begin
         submit(16'h5678, lat);
         tests++; if ({tries_left, game_over} !== {4'(9 - i), (i == 9)}) begin fails++; $display("FAIL tries[%0d] got %0d go%b want %0d go%b", i, tries_left, game_over, 9 - i, i == 9); end
         tick();
      end
      tests++; if (guess_ready !== 1'b0) begin fails++; $display("FAIL over_ready got %b want 0", guess_ready); end
      do_load(32'h0000_1234);
      tests++; if ({tries_left, game_over, guess_ready} !== {4'd10, 2'b01}) begin fails++; $display("FAIL reload_tries got %0d go%b r%b want 10 go0 r1", tries_left, game_over, guess_ready); end
`else
      for (int i = 0; i < 3; i++) begin
         submit(16'h5678, lat);
         tests++; if ({tries_left, game_over, result_valid} !== {4'd0, 2'b01}) begin fails++; $display("FAIL unlimited[%0d] got t%0d go%b rv%b want t0 go0 rv1", i, tries_left, game_over, result_valid); end
         tick();
      end
      tests++; if (guess_ready !== 1'b1) begin fails++; $display("FAIL unlimited_ready got %b want 1", guess_ready); end
`endif
   endtask

   initial begin
      test_reset();
      test_win();
      test_scoring();
      test_load_abort();
      test_reset_mid();
      test_attempt_limit();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
